// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares one single-port, synchronous-read instruction RAM
// between the CPU fetch port (read-only) and a loader/debug port (read/write).
// Latency: grant is combinational in the request cycle; read data returns 1 cycle later.
// Backpressure: the losing requester sees gnt=0 and must hold its request. Fetch wins
//   by default, the loader wins after MAX_STREAK fetch grants, and prog_mode blocks fetch.
//
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_prog_mode                         1 = fetch never granted
//   i_f_req/i_f_addr -> o_f_gnt         fetch request / byte address / accept
//   o_f_rvalid/o_f_rdata                fetch read return
//   i_l_req/i_l_we/i_l_addr/i_l_wdata   loader request, write enable, byte address, data
//   o_l_gnt/o_l_rvalid/o_l_rdata        loader accept and read return
//   o_l_err                             one-cycle pulse after a rejected misaligned write
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata   RAM interface
module imem_access_arbiter #(
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10,
  parameter int MAX_STREAK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_prog_mode,
  input  logic             i_f_req,
  input  logic [31:0]      i_f_addr,
  output logic             o_f_gnt,
  output logic             o_f_rvalid,
  output logic [31:0]      o_f_rdata,
  input  logic             i_l_req,
  input  logic             i_l_we,
  input  logic [31:0]      i_l_addr,
  input  logic [31:0]      i_l_wdata,
  output logic             o_l_gnt,
  output logic             o_l_rvalid,
  output logic [31:0]      o_l_rdata,
  output logic             o_l_err,
  output logic             o_mem_en,
  output logic             o_mem_we,
  output logic [IDX_W-1:0] o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  input  logic [31:0]      i_mem_rdata
);

  localparam logic [3:0] LP_MAX = 4'(MAX_STREAK);

  logic [3:0] r_streak;
  logic       r_f_tag;
  logic       r_l_tag;
  logic       r_l_err;

  logic       w_streak_full;
  logic       w_f_gnt;
  logic       w_l_gnt;
  logic       w_mis;
  logic [3:0] w_streak_nxt;

  // Upper address bits alias and fetch byte offset is ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^{i_f_addr[31:IDX_W+2], i_f_addr[1:0], i_l_addr[31:IDX_W+2]};

  assign w_streak_full = (r_streak >= LP_MAX);

  // Grants are qualified by reset so every output reads 0 while i_rst_n is low.
  assign w_f_gnt = i_rst_n & i_f_req & ~i_prog_mode & ~(i_l_req & w_streak_full);
  assign w_l_gnt = i_rst_n & i_l_req & (i_prog_mode | ~i_f_req | w_streak_full);

  // A misaligned loader write is accepted but kept away from the RAM.
  assign w_mis = w_l_gnt & i_l_we & (i_l_addr[1:0] != 2'b00);

  always_comb begin
    w_streak_nxt = r_streak;
    if (!i_l_req || w_l_gnt) begin
      w_streak_nxt = 4'd0;
    end else if (w_f_gnt && !w_streak_full) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_f_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_f_addr[IDX_W+1:2];
    end else if (w_l_gnt) begin
      o_mem_en    = ~w_mis;
      o_mem_we    = i_l_we & ~w_mis;
      o_mem_addr  = i_l_addr[IDX_W+1:2];
      o_mem_wdata = i_l_wdata;
    end
  end

  // Tags remember which port owns the read data arriving next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_streak <= 4'd0;
      r_f_tag  <= 1'b0;
      r_l_tag  <= 1'b0;
      r_l_err  <= 1'b0;
    end else begin
      r_streak <= w_streak_nxt;
      r_f_tag  <= w_f_gnt;
      r_l_tag  <= w_l_gnt & ~i_l_we;
      r_l_err  <= w_mis;
    end
  end

  assign o_f_gnt    = w_f_gnt;
  assign o_l_gnt    = w_l_gnt;
  assign o_f_rvalid = r_f_tag;
  assign o_l_rvalid = r_l_tag;
  assign o_f_rdata  = r_f_tag ? i_mem_rdata : 32'd0;
  assign o_l_rdata  = r_l_tag ? i_mem_rdata : 32'd0;
  assign o_l_err    = r_l_err;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb_imem_access_arbiter: directed stimulus with a cycle-stamped scoreboard for read returns.
// A behavioural single-port RAM sits behind the arbiter; read data checked per port.
// Grant/RAM-drive checks are inline at the falling edge after each stimulus cycle.
module tb_imem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_mode, f_req, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, l_err;
  logic [31:0] f_rdata, l_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_access_arbiter #(.DEPTH(1024), .IDX_W(10), .MAX_STREAK(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_prog_mode(prog_mode),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
    .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata), .o_l_err(l_err),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Behavioural synchronous-read RAM.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] dat; } exp_t;
  exp_t fq[$];
  exp_t lq[$];
  exp_t fe, le;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic push_f(input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.dat = d;
    fq.push_back(e);
  endtask

  task automatic push_l(input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.dat = d;
    lq.push_back(e);
  endtask

  // Monitor: every rvalid must match a queued expectation stamped with this cycle.
  always @(negedge clk) begin
    while (fq.size() > 0 && fq[0].cyc < cyc) begin
      flag("f_rvalid_missing");
      fe = fq.pop_front();
    end
    if (f_rvalid === 1'b1) begin
      if (fq.size() == 0 || fq[0].cyc != cyc) flag("f_rvalid_unexpected");
      else begin
        fe = fq.pop_front();
        chk("f_rdata", f_rdata, fe.dat);
      end
    end else begin
      chk("f_rdata_idle", f_rdata, 32'd0);
    end

    while (lq.size() > 0 && lq[0].cyc < cyc) begin
      flag("l_rvalid_missing");
      le = lq.pop_front();
    end
    if (l_rvalid === 1'b1) begin
      if (lq.size() == 0 || lq[0].cyc != cyc) flag("l_rvalid_unexpected");
      else begin
        le = lq.pop_front();
        chk("l_rdata", l_rdata, le.dat);
      end
    end else begin
      chk("l_rdata_idle", l_rdata, 32'd0);
    end
  end

  task automatic set_in(input logic pm, input logic fr, input logic [31:0] fa,
                        input logic lr, input logic lwe, input logic [31:0] la,
                        input logic [31:0] lwd);
    prog_mode = pm; f_req = fr; f_addr = fa;
    l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
  endtask

  task automatic drive(input logic pm, input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lwe, input logic [31:0] la,
                       input logic [31:0] lwd);
    @(posedge clk);
    #1;
    set_in(pm, fr, fa, lr, lwe, la, lwd);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_f_gnt"},     32'(f_gnt), 32'd0);
    chk({tag, "_l_gnt"},     32'(l_gnt), 32'd0);
    chk({tag, "_f_rvalid"},  32'(f_rvalid), 32'd0);
    chk({tag, "_l_rvalid"},  32'(l_rvalid), 32'd0);
    chk({tag, "_f_rdata"},   f_rdata, 32'd0);
    chk({tag, "_l_rdata"},   l_rdata, 32'd0);
    chk({tag, "_l_err"},     32'(l_err), 32'd0);
    chk({tag, "_mem_en"},    32'(mem_en), 32'd0);
    chk({tag, "_mem_we"},    32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    ram[0]  = 32'h0050_0093;
    ram[1]  = 32'h0010_0113;
    ram[2]  = 32'h0020_81B3;
    ram[8]  = 32'hCAFE_F00D;
    ram[16] = 32'h1111_2222;
    mem_rdata = 32'd0;
    rst_n = 1'b0;
    set_in(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF);

    // Reset: requests present but everything must read 0.
    @(negedge clk);
    chk_all_zero("rst");

    // Fetch only; first grant in the first cycle after release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("f0_f_gnt", 32'(f_gnt), 32'd1);
    chk("f0_l_gnt", 32'(l_gnt), 32'd0);
    chk("f0_mem_en", 32'(mem_en), 32'd1);
    chk("f0_mem_addr", 32'(mem_addr), 32'd0);
    push_f(32'h0050_0093);
    drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f1_f_gnt", 32'(f_gnt), 32'd1);
    chk("f1_l_gnt", 32'(l_gnt), 32'd0);
    chk("f1_mem_addr", 32'(mem_addr), 32'd1);
    push_f(32'h0010_0113);
    drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f2_f_gnt", 32'(f_gnt), 32'd1);
    chk("f2_l_gnt", 32'(l_gnt), 32'd0);
    chk("f2_mem_addr", 32'(mem_addr), 32'd2);
    push_f(32'h0020_81B3);

    // Starvation bound: two rounds of 4 fetch grants then one loader read.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        chk("stv_f_gnt", 32'(f_gnt), 32'd1);
        chk("stv_l_gnt", 32'(l_gnt), 32'd0);
        push_f(32'h0050_0093);
      end
      drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
      chk("stv_ld_l_gnt", 32'(l_gnt), 32'd1);
      chk("stv_ld_f_gnt", 32'(f_gnt), 32'd0);
      chk("stv_ld_mem_addr", 32'(mem_addr), 32'd16);
      chk("stv_ld_mem_we", 32'(mem_we), 32'd0);
      push_l(32'h1111_2222);
    end

    // Fetch read granted right before prog_mode rises must still return.
    drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_pm_f_gnt", 32'(f_gnt), 32'd1);
    push_f(32'h0010_0113);

    // prog_mode: write 0xDEADBEEF to 0x10, read it back; fetch stalled.
    drive(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("pm_wr_f_gnt", 32'(f_gnt), 32'd0);
    chk("pm_wr_l_gnt", 32'(l_gnt), 32'd1);
    chk("pm_wr_mem_en", 32'(mem_en), 32'd1);
    chk("pm_wr_mem_we", 32'(mem_we), 32'd1);
    chk("pm_wr_mem_addr", 32'(mem_addr), 32'd4);
    chk("pm_wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("pm_rd_f_gnt", 32'(f_gnt), 32'd0);
    chk("pm_rd_l_gnt", 32'(l_gnt), 32'd1);
    chk("pm_rd_mem_we", 32'(mem_we), 32'd0);
    chk("pm_rd_mem_addr", 32'(mem_addr), 32'd4);
    push_l(32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pm_idle_f_gnt", 32'(f_gnt), 32'd0);
    chk("pm_idle_mem_en", 32'(mem_en), 32'd0);

    // Misaligned write: accepted, RAM untouched, one-cycle l_err.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h22, 32'h5555_5555);
    chk("mis_l_gnt", 32'(l_gnt), 32'd1);
    chk("mis_mem_en", 32'(mem_en), 32'd0);
    chk("mis_mem_we", 32'(mem_we), 32'd0);
    chk("mis_l_err_now", 32'(l_err), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mis_l_err_next", 32'(l_err), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mis_l_err_after", 32'(l_err), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("mis_rb_l_gnt", 32'(l_gnt), 32'd1);
    chk("mis_rb_mem_addr", 32'(mem_addr), 32'd8);
    push_l(32'hCAFE_F00D);

    // Aliasing: 0x1004 maps to word 1.
    drive(1'b0, 1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("alias_f_gnt", 32'(f_gnt), 32'd1);
    chk("alias_mem_addr", 32'(mem_addr), 32'd1);
    push_f(32'h0010_0113);

    // Reset mid-read: the granted read at 0x8 must never return.
    drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rmr_f_gnt", 32'(f_gnt), 32'd1);
    chk("rmr_mem_addr", 32'(mem_addr), 32'd2);
    #1;
    rst_n = 1'b0;
    l_req = 1'b1;
    #1;
    chk_all_zero("rmr_async");
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("rmr_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rel_f_gnt", 32'(f_gnt), 32'd1);
    chk("rel_mem_addr", 32'(mem_addr), 32'd2);
    push_f(32'h0020_81B3);

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("lq_drained", 32'(lq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Shares one synchronous-read, single-port instruction RAM between two requesters:
  - the CPU fetch port, which is read-only;
  - a loader/debug port, which can read and write.
- Sits between the fetch stage and the instruction RAM. Through the loader port, software is written and checked at run time instead of only at elaboration.
- Fetch normally has priority. A streak counter guarantees the loader is served, and a prog_mode input stalls fetch entirely.

Parameters:
- DEPTH, 1024: RAM depth in 32-bit words; power of two.
- IDX_W, 10: word-index width; must equal log2(DEPTH).
- MAX_STREAK, 4: maximum consecutive fetch grants while l_req is pending; range 1..15.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_mode  in  1  1 = fetch is never granted.
- f_req  in  1  fetch request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  32  loader read data.
- l_err  out  1  one-cycle pulse: misaligned loader write was rejected.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  IDX_W  RAM word index.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid the cycle after mem_en=1 with mem_we=0.

Behaviour:
- **Decision rule:** at most one RAM access per cycle. The grant is combinational from the current inputs and the streak register. The decision order is:
  1. prog_mode=1: fetch blocked. l_gnt=l_req.
  2. f_req=1 and l_req=0: fetch granted.
  3. f_req=1, l_req=1, streak<MAX_STREAK: fetch granted.
  4. f_req=1, l_req=1, streak==MAX_STREAK: loader granted.
  5. f_req=0: l_gnt=l_req.
- **Streak counter:** 4 bits, reset 0.
  - Increments on a fetch grant while l_req=1.
  - Clears on any loader grant, or in any cycle with l_req=0.
  - Saturates at MAX_STREAK.
- **Address mapping:** mem_addr = granted address bits [IDX_W+1:2]. Upper bits are ignored, so addresses alias modulo DEPTH*4. Address bits [1:0] are ignored for reads.
- **RAM drive:**
  - mem_en=1 only in a grant cycle.
  - mem_we = l_we & l_gnt & (l_addr[1:0]==0).
  - mem_wdata = l_wdata.
  - When no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- **Misaligned write** (l_we=1, l_addr[1:0]!=0):
  - Still granted; the RAM is not written.
  - mem_en=0 in that cycle.
  - l_err=1 on the next cycle. l_err is registered, reset 0.
- **Read return:**
  - A registered tag records which port was granted a read.
  - The next cycle, exactly one of f_rvalid/l_rvalid is 1 for that port.
  - f_rdata/l_rdata = mem_rdata while the respective rvalid=1, otherwise 0.
  - Fixed latency is 1 cycle; back-to-back grants give back-to-back rvalid.
- **Writes** produce no rvalid.
- **prog_mode rise:** a fetch read granted in the previous cycle still returns its f_rvalid.
- **Reset:**
  - Asserting rst_n=0 immediately forces the tag, l_err and the streak counter to 0. An in-flight read's rvalid is dropped.
  - All outputs read 0 during reset: f_gnt, l_gnt, f_rvalid, l_rvalid, rdata, l_err, mem_en, mem_we, mem_addr, mem_wdata.
  - The first grant is possible in the first cycle after deassertion.

Test Plan:
- **Fetch only, no loader:** reset, then f_req=1 with f_addr=0x0,0x4,0x8 on consecutive cycles, RAM preloaded 0x00500093, 0x00100113, 0x002081B3 -> mem_addr=0,1,2; f_rvalid on cycles 2-4 with f_rdata equal to those words; l_gnt never 1.
- **Starvation bound:** f_req held 1, l_req=1 with l_we=0, l_addr=0x40, MAX_STREAK=4 -> f_gnt on 4 cycles, then l_gnt=1 on the 5th with mem_addr=16; the next cycle l_rvalid=1 and f_rvalid=0; the streak returns to 0.
- **prog_mode load and verify:** prog_mode=1, f_req=1, loader writes 0xDEADBEEF to 0x10 then reads 0x10 -> f_gnt=0 throughout; mem_we=1 with mem_addr=4; the read gives l_rvalid=1 and l_rdata=0xDEADBEEF one cycle after its grant.
- **Misaligned write:** l_we=1, l_addr=0x22 -> l_gnt=1, mem_en=0, mem_we=0; l_err=1 for exactly one cycle the next cycle; a RAM readback of index 8 is unchanged.
- **Aliasing:** fetch f_addr=0x00001004 with DEPTH=1024 -> mem_addr=1.
- **Reset mid-read:** f_gnt for f_addr=0x8, then rst_n=0 before the next edge -> f_rvalid stays 0; all outputs 0 during reset; after release, f_req=1 is granted in the first cycle.
